fairy_muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer for MULT, MULTU, DIV and DIVU. It sits beside the execute stage and shares one 64-bit add/subtract-and-shift datapath between multiply and divide. It stalls the pipeline while an operation runs and delivers the HI/LO result with write enables to the HI/LO register file. Exception or ERET cancels an operation in flight.

---
 rtl/fairy_muldiv_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_fairy_muldiv_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fairy_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer sharing one add/subtract-and-shift datapath.
// Stalls the pipeline while running and writes HI/LO on a one-cycle DONE pulse.
module fairy_muldiv_ctrl #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [1:0]  hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(ITER);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        opnd_q, opnd_d;
    logic [31:0]        raw_a_q, raw_a_d;
    logic [63:0]        acc_q, acc_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               accept;
    logic               last_iter;
    logic               in_signed;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic               is_div;
    logic [32:0]        add_x;
    logic [33:0]        add_y;
    logic [33:0]        sum;
    logic [63:0]        acc_step;
    logic [63:0]        prod;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    assign accept    = (state_q == S_IDLE) && start_i && !cancel_i;
    assign last_iter = (count_q == CNT_W'(ITER - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs; cancel overrides every transition
    always_comb begin
        state_d   = state_q;
        busy_o    = 1'b0;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        hilo_we_o = 2'b00;
        case (state_q)
            S_IDLE: begin
                stall_o = accept;
                if (accept) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                busy_o  = 1'b1;
                stall_o = 1'b1;
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                hilo_we_o = 2'b11;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (cancel_i) begin
            state_d = S_IDLE;
        end
    end

    // Operand magnitudes captured at accept
    always_comb begin
        in_signed = !op_i[0];
        abs_a     = (in_signed && src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
        abs_b     = (in_signed && src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;
    end

    // Shared 34-bit adder: add multiplicand (multiply) or subtract divisor (divide)
    always_comb begin
        is_div = op_q[1];
        add_x  = is_div ? acc_q[63:31] : {1'b0, acc_q[63:32]};
        add_y  = is_div ? ~{2'b00, opnd_q} : {2'b00, opnd_q};
        sum    = {1'b0, add_x} + add_y + 34'(is_div);
        if (!is_div) begin
            acc_step = acc_q[0] ? {sum[32:0], acc_q[31:1]} : {1'b0, acc_q[63:1]};
        end else if (sum[33]) begin
            acc_step = {acc_q[62:0], 1'b0};
        end else begin
            acc_step = {sum[31:0], acc_q[30:0], 1'b1};
        end
    end

    // Sign fixup on the final iteration result
    always_comb begin
        prod = acc_step;
        if (op_q == OP_MULT && (sign_a_q ^ sign_b_q)) begin
            prod = ~acc_step + 64'd1;
        end
        quo = acc_step[31:0];
        rem = acc_step[63:32];
        if (op_q == OP_DIV) begin
            if (sign_a_q ^ sign_b_q) begin
                quo = ~acc_step[31:0] + 32'd1;
            end
            if (sign_a_q) begin
                rem = ~acc_step[63:32] + 32'd1;
            end
        end
        if (!is_div) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (opnd_q == 32'd0) begin
            res_hi = raw_a_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    // Datapath next-state
    always_comb begin
        op_d     = op_q;
        opnd_d   = opnd_q;
        raw_a_d  = raw_a_q;
        acc_d    = acc_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (accept) begin
            op_d     = op_i;
            raw_a_d  = src_a_i;
            sign_a_d = in_signed && src_a_i[31];
            sign_b_d = in_signed && src_b_i[31];
            count_d  = '0;
            if (op_i[1]) begin
                acc_d  = {32'd0, abs_a};
                opnd_d = abs_b;
            end else begin
                acc_d  = {32'd0, abs_b};
                opnd_d = abs_a;
            end
        end else if (state_q == S_BUSY) begin
            acc_d   = acc_step;
            count_d = count_q + CNT_W'(1);
            if (last_iter && !cancel_i) begin
                hi_d = res_hi;
                lo_d = res_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= 2'b00;
            opnd_q   <= 32'd0;
            raw_a_q  <= 32'd0;
            acc_q    <= 64'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            count_q  <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            raw_a_q  <= raw_a_d;
            acc_q    <= acc_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_fairy_muldiv_ctrl.sv
// Self-checking bench for fairy_muldiv_ctrl: directed cases then random ops
// compared against an arithmetic reference model.
module tb_fairy_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        cancel_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [1:0]  hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_cmp = 0;
    int n_err = 0;

    fairy_muldiv_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .op_i      (op_i),
        .src_a_i   (src_a_i),
        .src_b_i   (src_b_i),
        .cancel_i  (cancel_i),
        .busy_o    (busy_o),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .hilo_we_o (hilo_we_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Called at a negedge in IDLE; returns at a negedge of the following IDLE cycle
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit cxl_done, output logic [31:0] hi_r, output logic [31:0] lo_r);
        logic [63:0] exp;
        int stalls;
        int k;
        exp = model(op, a, b);
        start_i = 1'b1;
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        #1;
        chk("stall_on_start", 64'(stall_o), 64'd1);
        stalls = 1;
        @(negedge clk);
        op_i    = 2'($urandom);
        src_a_i = $urandom;
        src_b_i = $urandom;
        k = 0;
        while (done_o !== 1'b1 && k < 100) begin
            if (stall_o === 1'b1) stalls++;
            start_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        start_i = 1'b0;
        chk("done_seen", 64'(done_o), 64'd1);
        chk("stall_cycles", 64'(stalls), 64'd33);
        chk("hi", 64'(hi_o), 64'(exp[63:32]));
        chk("lo", 64'(lo_o), 64'(exp[31:0]));
        chk("hilo_we", 64'(hilo_we_o), 64'd3);
        chk("stall_in_done", 64'(stall_o), 64'd0);
        hi_r = hi_o;
        lo_r = lo_o;
        if (cxl_done) begin
            cancel_i = 1'b1;
            #1;
            chk("done_under_cancel", 64'(done_o), 64'd1);
        end
        @(negedge clk);
        cancel_i = 1'b0;
        chk("done_pulse_end", 64'({done_o, hilo_we_o}), 64'd0);
        chk("idle_after_done", 64'(busy_o), 64'd0);
        chk("hilo_hold", {hi_o, lo_o}, exp);
    endtask

    initial begin
        logic [31:0] rh, rl, a, b;
        logic [1:0]  op;
        int seen;

        reset    = 1'b0;
        start_i  = 1'b0;
        cancel_i = 1'b0;
        op_i     = 2'b00;
        src_a_i  = 32'd0;
        src_b_i  = 32'd0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({busy_o, stall_o, done_o, hilo_we_o}), 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // start and cancel together in IDLE: not accepted
        start_i  = 1'b1;
        cancel_i = 1'b1;
        #1;
        chk("start_cancel_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        chk("start_cancel_busy", 64'(busy_o), 64'd0);
        start_i  = 1'b0;
        cancel_i = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'd5, 1'b0, rh, rl);
        chk("mult_m1x5", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl);
        chk("multu_max", {rh, rl}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl);
        chk("mult_m1xm1", {rh, rl}, 64'h0000_0000_0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, rh, rl);
        chk("div_m7_2", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, rh, rl);
        chk("divu_100_7", {rh, rl}, 64'h0000_0002_0000_000E);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, rh, rl);
        chk("div_min_m1", {rh, rl}, 64'h0000_0000_8000_0000);
        run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, rh, rl);
        chk("divu_by_zero", {rh, rl}, 64'h1234_5678_FFFF_FFFF);

        // cancel on the 10th BUSY cycle
        start_i = 1'b1;
        op_i    = 2'b11;
        src_a_i = 32'd1000;
        src_b_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_cancel", 64'(busy_o), 64'd1);
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        chk("cancel_idle", 64'({busy_o, stall_o, done_o, hilo_we_o}), 64'd0);
        run_op(2'b01, 32'd3, 32'd4, 1'b0, rh, rl);
        chk("multu_3x4", {rh, rl}, 64'h0000_0000_0000_000C);

        // asynchronous reset between clock edges mid-operation
        start_i = 1'b1;
        op_i    = 2'b00;
        src_a_i = 32'd77;
        src_b_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_ctl", 64'({busy_o, stall_o, done_o, hilo_we_o}), 64'd0);
        chk("async_reset_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o === 1'b1) seen++;
        end
        chk("no_done_after_reset", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    a = $urandom_range(0, 50);
                    b = $urandom_range(1, 9);
                    if ($urandom_range(0, 1) == 1) a = ~a + 32'd1;
                    if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
                end
                2: b = 32'd0;
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
                end
            endcase
            run_op(op, a, b, 1'($urandom_range(0, 1)), rh, rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
